freq_stat_4lane: RTL and testbench
==================================

# freq_stat_4lane

Byte-frequency statistics stage for the Huffman path. It counts symbol occurrences of an incoming 4-byte-per-cycle data block into four 256x18-bit count banks, one per byte lane. When the block ends it serves the banks through the read port consumed by the heap sorter (`freq_addrNa`/`freq_oe` in, `freq_valueNa`/`freq_valid` out), which sums the four lanes per symbol.

## Interface
Parameters:
- `CNT_W`, 18: count width per bank entry; counts saturate at 2^CNT_W-1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `stat_start`  in  1  pulse; begins clear and count of a new block. Accepted in any state.
- `stat_busy`  out  1  high in CLEAR, COUNT and FLUSH.
- `stat_done`  out  1  level; high in DONE until the next accepted `stat_start`.
- `data_in`  in  32  lane k = `data_in[8k+7:8k]`, k=0..3, maps to bank k+1.
- `data_byte_en`  in  4  per-lane enable; only lanes with their bit set are counted.
- `data_valid`  in  1  beat valid.
- `data_last`  in  1  final beat of block; qualified by `data_valid`.
- `data_ready`  out  1  high only in COUNT; a beat transfers when `data_valid` and `data_ready` are both high.
- `freq_oe`  in  1  read enable from the sorter.
- `freq_addr1a`..`freq_addr4a`  in  8 each  symbol address per bank.
- `freq_value1a`..`freq_value4a`  out  18 each  count read data.
- `freq_valid`  out  1  read data valid.

## Operation
- States: IDLE, CLEAR, COUNT, FLUSH, DONE.
- IDLE: outputs inactive. `stat_start` -> CLEAR.
- CLEAR: `clr_cnt` runs 0..255 and writes 0 to entry `clr_cnt` of all four banks, one entry per cycle. After entry 255 is written -> COUNT.
- COUNT: per lane, a 2-stage read-modify-write:
  - S1 issues a synchronous bank read at the byte value.
  - S2 computes new = old + 1, saturating at 262143, and writes it back.
- Forwarding: if S1 and S2 of the same lane hold the same byte, S1 uses S2's new value instead of stale RAM data. Back-to-back identical symbols must count exactly.
- Lanes are independent; identical bytes in different lanes of one beat update different banks, so there is no conflict.
- A transferred beat with `data_last` -> FLUSH. `data_ready` drops in the cycle after the last beat.
- FLUSH: 2 cycles; pipeline drains and the last writes land -> DONE.
- DONE:
  - `freq_oe` high with addresses -> `freq_valueNa` = bank[addr] one cycle later, and `freq_valid` = `freq_oe` delayed by 1.
  - Reads with `freq_oe` outside DONE return value 0 and `freq_valid` 0.
- `stat_start` in COUNT or FLUSH aborts the block: in-flight pipeline writes are dropped, `clr_cnt` is reset to 0 -> CLEAR.
- `stat_start` in DONE -> CLEAR; `stat_done` falls in the next cycle.
- A beat with `data_byte_en` = 0 and `data_last` = 1 is legal: it ends the block and counts nothing.

## Timing
- Reset values: state IDLE; `stat_busy`, `stat_done`, `data_ready`, `freq_valid` = 0; all `freq_valueNa` = 0; `clr_cnt` = 0; pipeline valids = 0. Bank contents are not cleared by `rst`.
- `stat_start` sampled at edge T: CLEAR for cycles T+1..T+256; `data_ready` is first high at T+257.
- Count write latency is 2 cycles after beat transfer.
- Last beat transferred at cycle L: FLUSH for L+1..L+2; `stat_done` high from L+3.
- Read latency: 1 cycle, registered output.
- `rst` mid-operation: returns to IDLE next edge; partial counts are invalid until the next CLEAR.

## Test plan
- `stat_start` pulse -> `stat_busy` next cycle; exactly 256 CLEAR cycles; `data_ready` rises 257 cycles after the start edge; all 1024 entries read 0.
- 4 beats of `0x03020100` with en=4'hF, last on the 4th -> bank1[0x00]=4, bank2[0x01]=4, bank3[0x02]=4, bank4[0x03]=4; all other entries 0; `stat_done` 3 cycles after the last beat.
- 1000 consecutive beats of `0xAAAAAAAA`, no gaps (forwarding) -> every bank[0xAA]=1000.
- Beat `0x11223344` with en=4'b0101 -> bank1[0x44]=1, bank3[0x22]=1, bank2[0x33]=0, bank4[0x11]=0.
- 262150 beats of byte 0x5A on lane0 only -> bank1[0x5A]=262143; no wrap to 0.
- `stat_start` mid-COUNT after 10 beats, then a new 1-beat block `0x00000000` -> bank1..4[0x00]=1 each; no residue from the aborted block. Read in DONE with `freq_oe` for one cycle -> `freq_valid` is a single 1-cycle pulse, one cycle later.

Source files
------------

// File: rtl/freq_stat_4lane.sv
// ----------------------------------------------------------------------------
// freq_stat_4lane
//
// Byte-frequency statistics stage for the Huffman path. Each cycle up to four
// bytes (one per lane) are counted into four independent 256-entry count
// banks (lane k -> bank k+1). When the block ends, the banks are served to the
// heap sorter through a registered read port, one address per bank.
//
// Ports:
//   clk, rst                  sole clock, synchronous active-high reset
//   stat_start                pulse: clear the banks and count a new block
//   stat_busy                 high while clearing, counting or flushing
//   stat_done                 high once the block's counts are readable
//   data_in[31:0]             lane k = data_in[8k+7:8k]
//   data_byte_en[3:0]         per-lane count enable
//   data_valid, data_last     beat valid / final beat of block
//   data_ready                high only while counting
//   freq_oe                   read enable from the sorter
//   freq_addr1a..4a           symbol address per bank
//   freq_value1a..4a          count read data (one cycle after the request)
//   freq_valid                read data valid (freq_oe delayed by one cycle)
//   o_dbg_state               current FSM state encoding
//
// Handshake: a beat transfers on a rising edge where data_valid and
// data_ready are both high; data_ready depends only on the FSM state, never
// on data_valid, and data_last is only meaningful on a transferring beat.
// ----------------------------------------------------------------------------
module freq_stat_4lane #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stat_start,
    output logic             stat_busy,
    output logic             stat_done,
    input  logic [31:0]      data_in,
    input  logic [3:0]       data_byte_en,
    input  logic             data_valid,
    input  logic             data_last,
    output logic             data_ready,
    input  logic             freq_oe,
    input  logic [7:0]       freq_addr1a,
    input  logic [7:0]       freq_addr2a,
    input  logic [7:0]       freq_addr3a,
    input  logic [7:0]       freq_addr4a,
    output logic [CNT_W-1:0] freq_value1a,
    output logic [CNT_W-1:0] freq_value2a,
    output logic [CNT_W-1:0] freq_value3a,
    output logic [CNT_W-1:0] freq_value4a,
    output logic             freq_valid,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_COUNT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_clr_cnt;
    logic             r_flush_cnt;
    logic             r_freq_valid;
    logic             w_beat_xfer;
    logic [7:0]       w_freq_addr [4];
    logic [CNT_W-1:0] w_freq_value [4];

    assign w_freq_addr[0] = freq_addr1a;
    assign w_freq_addr[1] = freq_addr2a;
    assign w_freq_addr[2] = freq_addr3a;
    assign w_freq_addr[3] = freq_addr4a;

    assign w_beat_xfer = data_valid && data_ready;

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        stat_busy    = 1'b0;
        stat_done    = 1'b0;
        data_ready   = 1'b0;

        case (r_state)
            ST_IDLE:  ;
            ST_CLEAR: if (r_clr_cnt == 8'hFF) w_next_state = ST_COUNT;
            ST_COUNT: if (w_beat_xfer && data_last) w_next_state = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt) w_next_state = ST_DONE;
            ST_DONE:  ;
            default:  w_next_state = ST_IDLE;
        endcase
        // A new block may be requested from any state, including mid-count.
        if (stat_start) w_next_state = ST_CLEAR;

        case (r_state)
            ST_CLEAR: stat_busy = 1'b1;
            ST_COUNT: begin
                stat_busy  = 1'b1;
                data_ready = 1'b1;
            end
            ST_FLUSH: stat_busy = 1'b1;
            ST_DONE:  stat_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_flush_cnt  <= 1'b0;
            r_freq_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Clear address restarts on every accepted start.
            if (stat_start || r_state != ST_CLEAR) r_clr_cnt <= '0;
            else                                    r_clr_cnt <= r_clr_cnt + 8'd1;
            // FLUSH lasts exactly two cycles: r_flush_cnt marks the second.
            r_flush_cnt  <= (r_state == ST_FLUSH) && !stat_start && !r_flush_cnt;
            r_freq_valid <= freq_oe && (r_state == ST_DONE);
        end
    end

    assign o_dbg_state = r_state;

    // ------------------------------------------------------------------
    // Per-lane count bank with 2-stage read-modify-write
    //   beat edge : bank read issued at the byte value      (S1 captured)
    //   S1 cycle  : old count (forwarded if needed) + 1     (S2 captured)
    //   S2 edge   : new count written back
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [CNT_W-1:0] r_mem [256];
        logic [CNT_W-1:0] r_rd_data;
        logic             r_s1_vld;
        logic [7:0]       r_s1_byte;
        logic             r_s2_vld;
        logic [7:0]       r_s2_byte;
        logic [CNT_W-1:0] r_s2_val;
        logic [7:0]       w_byte;
        logic [7:0]       w_rd_addr;
        logic             w_wr_en;
        logic [7:0]       w_wr_addr;
        logic [CNT_W-1:0] w_wr_data;
        logic [CNT_W-1:0] w_old;
        logic [CNT_W-1:0] w_new;

        assign w_byte = data_in[8*k +: 8];

        // The single read port serves the counter until DONE, then the sorter.
        assign w_rd_addr = (r_state == ST_DONE) ? w_freq_addr[k] : w_byte;

        always_comb begin
            w_wr_en   = 1'b0;
            w_wr_addr = r_s2_byte;
            w_wr_data = r_s2_val;
            if (r_state == ST_CLEAR) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_cnt;
                w_wr_data = '0;
            end else if (r_s2_vld && !stat_start) begin
                // An abort drops the write still sitting in S2.
                w_wr_en = 1'b1;
            end
        end

        // S2 holds the newest value of its byte, which the bank has not yet
        // seen; it wins over the RAM data for an identical symbol in S1.
        assign w_old = (r_s2_vld && (r_s2_byte == r_s1_byte)) ? r_s2_val : r_rd_data;
        assign w_new = (w_old == CNT_MAX) ? w_old : (w_old + CNT_ONE);

        // Bank storage is deliberately left out of reset. Read-during-write
        // to the same entry returns the data being written, which covers the
        // case where a symbol repeats two beats apart (its write lands on
        // the edge that reads it again).
        always_ff @(posedge clk) begin
            if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
            r_rd_data <= (w_wr_en && (w_wr_addr == w_rd_addr)) ? w_wr_data : r_mem[w_rd_addr];
        end

        always_ff @(posedge clk) begin
            if (rst || stat_start) begin
                r_s1_vld  <= 1'b0;
                r_s1_byte <= '0;
                r_s2_vld  <= 1'b0;
                r_s2_byte <= '0;
                r_s2_val  <= '0;
            end else begin
                r_s1_vld  <= w_beat_xfer && data_byte_en[k];
                r_s1_byte <= w_byte;
                r_s2_vld  <= r_s1_vld;
                r_s2_byte <= r_s1_byte;
                r_s2_val  <= w_new;
            end
        end

        // Read data is only presented for reads accepted in DONE.
        assign w_freq_value[k] = r_freq_valid ? r_rd_data : '0;
    end

    assign freq_value1a = w_freq_value[0];
    assign freq_value2a = w_freq_value[1];
    assign freq_value3a = w_freq_value[2];
    assign freq_value4a = w_freq_value[3];
    assign freq_valid   = r_freq_valid;

endmodule

// File: tb/tb_freq_stat_4lane.sv
// Bench for freq_stat_4lane. A second instance with a 5-bit count width shares
// all inputs so that saturation is exercised within a short run.
module tb_freq_stat_4lane;
  localparam int CNT_W = 18;
  localparam int SAT_W = 5;
  localparam int MAX_M = 262143;
  localparam int MAX_S = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             stat_start = 1'b0;
  logic [31:0]      data_in = '0;
  logic [3:0]       data_byte_en = '0;
  logic             data_valid = 1'b0;
  logic             data_last = 1'b0;
  logic             freq_oe = 1'b0;
  logic [7:0]       addrs [4];
  logic             stat_busy, stat_done, data_ready, freq_valid;
  logic [2:0]       dbg_state;
  logic [CNT_W-1:0] vals [4];
  logic             s_busy, s_done, s_ready, s_valid;
  logic [2:0]       s_dbg;
  logic [SAT_W-1:0] svals [4];

  freq_stat_4lane #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .stat_start(stat_start),
    .stat_busy(stat_busy), .stat_done(stat_done),
    .data_in(data_in), .data_byte_en(data_byte_en),
    .data_valid(data_valid), .data_last(data_last), .data_ready(data_ready),
    .freq_oe(freq_oe),
    .freq_addr1a(addrs[0]), .freq_addr2a(addrs[1]),
    .freq_addr3a(addrs[2]), .freq_addr4a(addrs[3]),
    .freq_value1a(vals[0]), .freq_value2a(vals[1]),
    .freq_value3a(vals[2]), .freq_value4a(vals[3]),
    .freq_valid(freq_valid), .o_dbg_state(dbg_state)
  );

  freq_stat_4lane #(.CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .stat_start(stat_start),
    .stat_busy(s_busy), .stat_done(s_done),
    .data_in(data_in), .data_byte_en(data_byte_en),
    .data_valid(data_valid), .data_last(data_last), .data_ready(s_ready),
    .freq_oe(freq_oe),
    .freq_addr1a(addrs[0]), .freq_addr2a(addrs[1]),
    .freq_addr3a(addrs[2]), .freq_addr4a(addrs[3]),
    .freq_value1a(svals[0]), .freq_value2a(svals[1]),
    .freq_value3a(svals[2]), .freq_value4a(svals[3]),
    .freq_valid(s_valid), .o_dbg_state(s_dbg)
  );

  // ---------------- reference model and scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cnt [4][256];
  logic [CNT_W-1:0] exp_q [$];
  logic [SAT_W-1:0] exp_s_q [$];

  function automatic int clip(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 256; a++) cnt[k][a] = 0;
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  // Pulses stat_start, then checks CLEAR length, ready latency and that a
  // read outside DONE returns nothing.
  task automatic start_block();
    int n;
    int clr;
    stat_start = 1'b1;
    @(negedge clk);
    stat_start = 1'b0;
    data_valid = 1'b0;
    data_last  = 1'b0;
    model_clear();
    chk("busy_after_start", {31'd0, stat_busy}, 32'd1);
    chk("done_after_start", {31'd0, stat_done}, 32'd0);
    freq_oe = 1'b1;
    for (int k = 0; k < 4; k++) addrs[k] = 8'h00;
    n = 0;
    clr = 0;
    while (!data_ready && n < 400) begin
      if (stat_busy) clr++;
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("rd_outside_done_valid", {31'd0, freq_valid}, 32'd0);
        chk("rd_outside_done_value", {14'd0, vals[0]}, 32'd0);
        freq_oe = 1'b0;
      end
    end
    chk("clear_cycles", clr, 32'd256);
    chk("ready_latency", n + 1, 32'd257);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] en, input logic last, input logic vld);
    data_in      = d;
    data_byte_en = en;
    data_last    = last;
    data_valid   = vld;
    if (vld && data_ready)
      for (int k = 0; k < 4; k++)
        if (en[k]) cnt[k][d[8*k +: 8]]++;
    @(negedge clk);
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  // Called at the falling edge right after the last beat transferred.
  task automatic flush_checks();
    chk("flush1_busy", {31'd0, stat_busy}, 32'd1);
    chk("flush1_ready", {31'd0, data_ready}, 32'd0);
    chk("flush1_done", {31'd0, stat_done}, 32'd0);
    @(negedge clk);
    chk("flush2_busy", {31'd0, stat_busy}, 32'd1);
    chk("flush2_done", {31'd0, stat_done}, 32'd0);
    @(negedge clk);
    chk("done_at_l3", {31'd0, stat_done}, 32'd1);
    chk("busy_at_l3", {31'd0, stat_busy}, 32'd0);
  endtask

  // One-cycle read of four addresses with explicit expected counts; also
  // checks that freq_valid is a single-cycle pulse.
  task automatic read_check(input logic [31:0] a, input logic [3:0][19:0] e);
    for (int k = 0; k < 4; k++) addrs[k] = a[8*k +: 8];
    freq_oe = 1'b1;
    @(negedge clk);
    freq_oe = 1'b0;
    chk("rd_valid_pulse", {31'd0, freq_valid}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_lane%0d", k), {14'd0, vals[k]}, {12'd0, e[k]});
      chk($sformatf("rd_sat_lane%0d", k), {27'd0, svals[k]}, clip(int'(e[k]), MAX_S));
    end
    @(negedge clk);
    chk("rd_valid_end", {31'd0, freq_valid}, 32'd0);
  endtask

  // Back-to-back read of every entry of every bank against the model.
  task automatic dump_check();
    logic [CNT_W-1:0] e;
    logic [SAT_W-1:0] es;
    for (int a = 0; a <= 256; a++) begin
      if (a > 0) begin
        chk("dump_valid", {31'd0, freq_valid}, 32'd1);
        for (int k = 0; k < 4; k++) begin
          e  = exp_q.pop_front();
          es = exp_s_q.pop_front();
          chk($sformatf("dump_b%0d_%02h", k + 1, addrs[k]), {14'd0, vals[k]}, {14'd0, e});
          chk($sformatf("dump_sat_b%0d_%02h", k + 1, addrs[k]), {27'd0, svals[k]}, {27'd0, es});
        end
      end
      if (a < 256) begin
        for (int k = 0; k < 4; k++) begin
          addrs[k] = 8'(a + 64 * k);
          exp_q.push_back(CNT_W'(clip(cnt[k][addrs[k]], MAX_M)));
          exp_s_q.push_back(SAT_W'(clip(cnt[k][addrs[k]], MAX_S)));
        end
        freq_oe = 1'b1;
      end else begin
        freq_oe = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    for (int k = 0; k < 4; k++)
      d[8*k +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h10 + $urandom_range(0, 3));
    return d;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0]      data;
    logic [3:0]       en;
    int               reps;
    logic [31:0]      chk_addrs;
    logic [3:0][19:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk_vec(input logic [31:0] d, input logic [3:0] en, input int reps,
                                  input logic [31:0] a, input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.data      = d;
    v.en        = en;
    v.reps      = reps;
    v.chk_addrs = a;
    v.exp_cnt   = {20'(e3), 20'(e2), 20'(e1), 20'(e0)};
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 4; k++) addrs[k] = 8'h00;
    vecs[0] = mk_vec(32'h00000000, 4'h0, 1,    32'h00000000, 0, 0, 0, 0);
    vecs[1] = mk_vec(32'h03020100, 4'hF, 4,    32'h03020100, 4, 4, 4, 4);
    vecs[2] = mk_vec(32'hAAAAAAAA, 4'hF, 1000, 32'hAAAAAAAA, 1000, 1000, 1000, 1000);
    vecs[3] = mk_vec(32'h11223344, 4'b0101, 1, 32'h11223344, 1, 0, 1, 0);
    vecs[4] = mk_vec(32'h0000005A, 4'b0001, 40, 32'h5A5A5A5A, 40, 0, 0, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, stat_busy}, 32'd0);
    chk("rst_done", {31'd0, stat_done}, 32'd0);
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_valid", {31'd0, freq_valid}, 32'd0);
    chk("rst_value1", {14'd0, vals[0]}, 32'd0);
    chk("rst_value4", {14'd0, vals[3]}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      start_block();
      for (int r = 0; r < vecs[v].reps; r++)
        send_beat(vecs[v].data, vecs[v].en, r == vecs[v].reps - 1, 1'b1);
      flush_checks();
      read_check(vecs[v].chk_addrs, vecs[v].exp_cnt);
      dump_check();
    end

    // Randomised blocks with gaps and repeated symbols.
    for (int b = 0; b < 3; b++) begin
      int nb;
      nb = $urandom_range(60, 150);
      start_block();
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 4) == 0) send_beat(rand_data(), 4'hF, 1'b0, 1'b0);
        send_beat(rand_data(), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, i == nb - 1, 1'b1);
      end
      flush_checks();
      dump_check();
    end

    // Abort mid-count, then a one-beat block of zeros.
    start_block();
    for (int i = 0; i < 10; i++) send_beat(rand_data(), 4'hF, 1'b0, 1'b1);
    data_in = rand_data();
    data_byte_en = 4'hF;
    data_valid = 1'b1;
    start_block();
    send_beat(32'h00000000, 4'hF, 1'b1, 1'b1);
    flush_checks();
    read_check(32'h00000000, {20'd1, 20'd1, 20'd1, 20'd1});
    dump_check();

    // Reset mid-count returns to IDLE on the next edge.
    start_block();
    for (int i = 0; i < 3; i++) send_beat(rand_data(), 4'hF, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, stat_busy}, 32'd0);
    chk("midrst_ready", {31'd0, data_ready}, 32'd0);
    chk("midrst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
